// File: rtl/cache_pkg.sv
// Shared geometry and types for the cache miss/fill controller.
//
// A cache block is 16 bytes = 8 halfword-aligned 16-bit words. Address
// bits [3:1] select the word within the block and bits [9:4] select one of
// the 64 sets. Everything here is consumed through import cache_pkg::*.
package cache_pkg;

    localparam int ADDR_W      = 16;
    localparam int CNT_W       = 3;
    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_BITS = 4;
    localparam int SET_BITS    = 6;

    localparam logic TARGET_I = 1'b0;
    localparam logic TARGET_D = 1'b1;

    // Counter value of the final word of a block.
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    // Clears the byte-offset bits so a miss address becomes its block base.
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFFSET_BITS) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fill_state_t;

    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return addr & BASE_MASK;
    endfunction

    // The word index only ever lands in bits [3:1]; with a masked base the
    // OR can never carry into the set bits.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  cnt);
        return base | {{(ADDR_W-CNT_W-1){1'b0}}, cnt, 1'b0};
    endfunction

    function automatic logic [SET_BITS-1:0] set_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_BITS +: SET_BITS];
    endfunction

endpackage

// File: rtl/cache_fill_counter.sv
// Word counter for the fill controller (used for both the request and the
// return side of a block fill).
//
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset, clears the count
//   clr_i  synchronous clear, wins over en_i
//   en_i   advance by one; wraps 7 -> 0
//   cnt_o  current count
module cache_fill_counter
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-handling controller shared by the I-cache and D-cache.
//
// On a miss it owns the single main-memory read port, issues the 8 word reads
// of the 16-byte block on consecutive cycles, streams each returned word into
// the target cache's data array and writes the tag together with the last
// word. The D-cache wins simultaneous misses; a grant is never preempted.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   icache_miss/_addr              I-side miss request (level) and address
//   dcache_miss/_addr              D-side miss request (level) and address
//   mem_en, mem_addr               memory read request, word-aligned address
//   mem_data_valid, mem_data_in    memory read return (in issue order)
//   mem_busy                       controller is filling; stores hold off
//   fill_target                    0 = I-cache, 1 = D-cache
//   fill_word_wr/_addr, fill_data_out   data-array word write
//   tag_wr                         tag/valid write for fill_word_addr's set
//   icache_fill_done, dcache_fill_done  one-cycle completion pulses
//   icache_stall, dcache_stall     pipeline stalls
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no fill; arbitrate pending misses, counters held cleared
// ISSUE | one read request per cycle for words 0..7, returns accepted
// DRAIN | all requests sent, waiting for the remaining returns
module cache_fill_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_miss_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_miss_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    input  logic [ADDR_W-1:0] mem_data_in,
    output logic              mem_busy,
    output logic              fill_target,
    output logic              fill_word_wr,
    output logic [ADDR_W-1:0] fill_word_addr,
    output logic [ADDR_W-1:0] fill_data_out,
    output logic              tag_wr,
    output logic              icache_fill_done,
    output logic              dcache_fill_done,
    output logic              icache_stall,
    output logic              dcache_stall
);

    fill_state_t       state_q;
    fill_state_t       state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_d;
    logic              target_q;
    logic              target_d;

    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              cnt_clr;
    logic              issue_en;
    logic              recv_en;
    logic              busy;
    logic              recv_active;

    cache_fill_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (issue_en),
        .cnt_o (issue_cnt)
    );

    cache_fill_counter u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (recv_en),
        .cnt_o (recv_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            target_q <= TARGET_I;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            target_q <= target_d;
        end
    end

    assign busy        = (state_q != IDLE);
    // Returns seen while IDLE belong to a fill killed by reset and are dropped.
    assign recv_active = (state_q == ISSUE) || (state_q == DRAIN);

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        target_d         = target_q;
        cnt_clr          = 1'b0;
        issue_en         = 1'b0;
        recv_en          = 1'b0;
        mem_en           = 1'b0;
        mem_addr         = '0;
        fill_word_wr     = 1'b0;
        fill_word_addr   = '0;
        fill_data_out    = '0;
        tag_wr           = 1'b0;
        icache_fill_done = 1'b0;
        dcache_fill_done = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (dcache_miss) begin
                    base_d   = block_base(dcache_miss_addr);
                    target_d = TARGET_D;
                    state_d  = ISSUE;
                end else if (icache_miss) begin
                    base_d   = block_base(icache_miss_addr);
                    target_d = TARGET_I;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = word_addr(base_q, issue_cnt);
                issue_en = 1'b1;
                if (issue_cnt == LAST_WORD) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The receive path overrides the issue-side transition: with a
        // zero-latency memory the last word could return while still in ISSUE.
        if (recv_active && mem_data_valid) begin
            fill_word_wr   = 1'b1;
            fill_word_addr = word_addr(base_q, recv_cnt);
            fill_data_out  = mem_data_in;
            recv_en        = 1'b1;
            if (recv_cnt == LAST_WORD) begin
                tag_wr = 1'b1;
                if (target_q == TARGET_D) begin
                    dcache_fill_done = 1'b1;
                end else begin
                    icache_fill_done = 1'b1;
                end
                state_d = IDLE;
            end
        end
    end

    assign mem_busy     = busy;
    assign fill_target  = target_q;
    assign icache_stall = icache_miss | (busy & (target_q == TARGET_I));
    assign dcache_stall = dcache_miss | (busy & (target_q == TARGET_D));

endmodule

// File: tb/tb_cache_fill_ctrl.sv
module tb_cache_fill_ctrl;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        icache_miss = 1'b0;
    logic [15:0] icache_miss_addr = 16'h0;
    logic        dcache_miss = 1'b0;
    logic [15:0] dcache_miss_addr = 16'h0;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_data_in = 16'h0;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_busy;
    logic        fill_target;
    logic        fill_word_wr;
    logic [15:0] fill_word_addr;
    logic [15:0] fill_data_out;
    logic        tag_wr;
    logic        icache_fill_done;
    logic        dcache_fill_done;
    logic        icache_stall;
    logic        dcache_stall;

    cache_fill_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .icache_miss      (icache_miss),
        .icache_miss_addr (icache_miss_addr),
        .dcache_miss      (dcache_miss),
        .dcache_miss_addr (dcache_miss_addr),
        .mem_en           (mem_en),
        .mem_addr         (mem_addr),
        .mem_data_valid   (mem_data_valid),
        .mem_data_in      (mem_data_in),
        .mem_busy         (mem_busy),
        .fill_target      (fill_target),
        .fill_word_wr     (fill_word_wr),
        .fill_word_addr   (fill_word_addr),
        .fill_data_out    (fill_data_out),
        .tag_wr           (tag_wr),
        .icache_fill_done (icache_fill_done),
        .dcache_fill_done (dcache_fill_done),
        .icache_stall     (icache_stall),
        .dcache_stall     (dcache_stall)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          lat_cfg = 4;
    bit          bubble_en = 1'b0;
    int          bubble_left = 0;
    logic [15:0] salt = 16'h0;
    logic [15:0] last_wr_addr = 16'h0;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } pend_t;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
        logic        tgt;
    } rec_t;

    pend_t pend[$];
    rec_t  req_q[$];
    rec_t  wr_q[$];
    rec_t  tag_q[$];
    rec_t  done_q[$];

    // Memory: a request made in cycle c returns in cycle c+L (in order);
    // optional 2-cycle bubble after the word at block offset index 3.
    initial begin : mem_model
        pend_t p;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            mem_data_valid = 1'b0;
            mem_data_in    = 16'h0;
            if (bubble_left > 0) begin
                bubble_left = bubble_left - 1;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                p = pend.pop_front();
                mem_data_valid = 1'b1;
                mem_data_in    = p.addr ^ salt;
                if (bubble_en && p.addr[3:1] == 3'd3) bubble_left = 2;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mem_en) begin
                pend.push_back('{due: cyc + lat_cfg, addr: mem_addr});
                req_q.push_back('{cyc, mem_addr, 16'h0, 1'b0});
            end
            if (fill_word_wr)     wr_q.push_back('{cyc, fill_word_addr, fill_data_out, fill_target});
            if (tag_wr)           tag_q.push_back('{cyc, fill_word_addr, 16'h0, fill_target});
            if (icache_fill_done) done_q.push_back('{cyc, 16'h0, 16'h0, 1'b0});
            if (dcache_fill_done) done_q.push_back('{cyc, 16'h0, 16'h0, 1'b1});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_en"},   mem_en, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_busy"},     mem_busy, 0);
        chk({tag, "_target"},   fill_target, 0);
        chk({tag, "_wr"},       fill_word_wr, 0);
        chk({tag, "_waddr"},    fill_word_addr, 0);
        chk({tag, "_wdata"},    fill_data_out, 0);
        chk({tag, "_tag_wr"},   tag_wr, 0);
        chk({tag, "_idone"},    icache_fill_done, 0);
        chk({tag, "_ddone"},    dcache_fill_done, 0);
        chk({tag, "_istall"},   icache_stall, 0);
        chk({tag, "_dstall"},   dcache_stall, 0);
    endtask

    // Steps until the target's done pulse; checks busy and stalls en route.
    task automatic wait_done(input logic t, input string tag, output int dc);
        dc = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            chk({tag, "_busy"},   mem_busy, 1);
            chk({tag, "_istall"}, icache_stall, icache_miss | (t == TARGET_I));
            chk({tag, "_dstall"}, dcache_stall, dcache_miss | (t == TARGET_D));
            if ((t == TARGET_D) ? dcache_fill_done : icache_fill_done) begin
                dc = cyc;
                break;
            end
        end
        chk({tag, "_done_seen"}, dc >= 0, 1);
    endtask

    // Expected block transfer for a miss visible in cycle T.
    task automatic check_fill(input string tag, input logic t, input logic [15:0] miss_addr,
                              input int T, input int L, input bit bub);
        logic [15:0] b;
        logic [15:0] ea;
        int          wc;
        int          last_c;
        rec_t        r;
        b = miss_addr & 16'hFFF0;
        last_c = T + 8 + L + (bub ? 2 : 0);
        for (int k = 0; k < 8; k++) begin
            ea = b + 16'(2 * k);
            chk({tag, "_req_present"}, req_q.size() > 0, 1);
            if (req_q.size() > 0) begin
                r = req_q.pop_front();
                chk({tag, "_req_cyc"},  r.cyc, T + 1 + k);
                chk({tag, "_req_addr"}, r.addr, ea);
            end
            wc = T + 1 + L + k + ((bub && k >= 4) ? 2 : 0);
            chk({tag, "_wr_present"}, wr_q.size() > 0, 1);
            if (wr_q.size() > 0) begin
                r = wr_q.pop_front();
                chk({tag, "_wr_cyc"},  r.cyc, wc);
                chk({tag, "_wr_addr"}, r.addr, ea);
                chk({tag, "_wr_data"}, r.data, ea ^ salt);
                chk({tag, "_wr_tgt"},  r.tgt, t);
                last_wr_addr = r.addr;
            end
        end
        chk({tag, "_tag_present"}, tag_q.size() > 0, 1);
        if (tag_q.size() > 0) begin
            r = tag_q.pop_front();
            chk({tag, "_tag_cyc"},  r.cyc, last_c);
            chk({tag, "_tag_addr"}, r.addr, b + 16'hE);
            chk({tag, "_tag_tgt"},  r.tgt, t);
        end
        chk({tag, "_done_present"}, done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
            r = done_q.pop_front();
            chk({tag, "_done_cyc"}, r.cyc, last_c);
            chk({tag, "_done_tgt"}, r.tgt, t);
        end
    endtask

    task automatic finish_scenario(input string tag);
        for (int i = 0; i < 60 && pend.size() > 0; i++) tick();
        tick();
        chk({tag, "_extra_req"},  req_q.size(), 0);
        chk({tag, "_extra_wr"},   wr_q.size(), 0);
        chk({tag, "_extra_tag"},  tag_q.size(), 0);
        chk({tag, "_extra_done"}, done_q.size(), 0);
        req_q.delete();
        wr_q.delete();
        tag_q.delete();
        done_q.delete();
    endtask

    task automatic single_fill(input logic t, input logic [15:0] a, input int L,
                               input bit bub, input string tag);
        int T;
        int dc;
        lat_cfg   = L;
        bubble_en = bub;
        if (t == TARGET_D) begin
            dcache_miss = 1'b1;
            dcache_miss_addr = a;
        end else begin
            icache_miss = 1'b1;
            icache_miss_addr = a;
        end
        T = cyc;
        wait_done(t, tag, dc);
        tick();
        icache_miss = 1'b0;
        dcache_miss = 1'b0;
        chk({tag, "_idle_busy"}, mem_busy, 0);
        check_fill(tag, t, a, T, L, bub);
        finish_scenario(tag);
    endtask

    // D miss at T, I miss delay cycles later (0 = simultaneous).
    task automatic two_fills(input logic [15:0] ai, input logic [15:0] ad, input int L,
                             input int delay, input string tag);
        int Td;
        int Ti;
        int dd;
        int di;
        lat_cfg   = L;
        bubble_en = 1'b0;
        dcache_miss = 1'b1;
        dcache_miss_addr = ad;
        Td = cyc;
        if (delay > 0) repeat (delay) tick();
        icache_miss = 1'b1;
        icache_miss_addr = ai;
        wait_done(TARGET_D, {tag, "_d"}, dd);
        tick();
        dcache_miss = 1'b0;
        Ti = cyc;
        wait_done(TARGET_I, {tag, "_i"}, di);
        tick();
        icache_miss = 1'b0;
        chk({tag, "_idle_busy"}, mem_busy, 0);
        check_fill({tag, "_d"}, TARGET_D, ad, Td, L, 1'b0);
        check_fill({tag, "_i"}, TARGET_I, ai, Ti, L, 1'b0);
        finish_scenario(tag);
    endtask

    initial begin : main
        int n;
        int nw;
        int nt;
        int nd;
        int nr;
        salt = 16'($urandom);

        rst = 1'b1;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        single_fill(TARGET_I, 16'h1234, 4, 1'b0, "imiss");
        two_fills(16'h0040, 16'h0380, 4, 0, "simul");
        two_fills(16'($urandom), 16'($urandom), 3, 3, "late");
        single_fill(TARGET_D, 16'h5A26, 4, 1'b1, "bubble");

        // Reset after the 4th word write; later stray returns must be ignored.
        lat_cfg   = 3;
        bubble_en = 1'b0;
        icache_miss = 1'b1;
        icache_miss_addr = 16'($urandom);
        n = 0;
        while (wr_q.size() < 4 && n < 60) begin
            tick();
            n++;
        end
        chk("rst_reached_word4", wr_q.size() >= 4, 1);
        rst = 1'b1;
        icache_miss = 1'b0;
        tick();
        chk_zero("rst_mid");
        rst = 1'b0;
        nw = wr_q.size();
        nt = tag_q.size();
        nd = done_q.size();
        nr = req_q.size();
        repeat (12) tick();
        chk("rst_stray_wr",   wr_q.size(), nw);
        chk("rst_stray_tag",  tag_q.size(), nt);
        chk("rst_stray_done", done_q.size(), nd);
        chk("rst_stray_req",  req_q.size(), nr);
        chk("rst_stray_busy", mem_busy, 0);
        req_q.delete();
        wr_q.delete();
        tag_q.delete();
        done_q.delete();
        finish_scenario("rst_post");

        single_fill(TARGET_D, 16'hFFFF, 2, 1'b0, "setbnd");
        chk("setbnd_last_addr", last_wr_addr, 16'hFFFE);
        chk("setbnd_set", set_index(last_wr_addr), 6'd63);

        for (int i = 0; i < 6; i++) begin
            single_fill(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, 6),
                        1'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling controller shared by the I-cache and D-cache. On a miss it grants the single main-memory read port to one cache and issues the 8 word reads of the 16-byte block. It streams the returned words into that cache's data array, then writes the tag. The 16-bit fill word address it drives feeds the cache's 64-set one-hot decoder (set = addr[9:4]) and word select (addr[3:1]).

## Interface
- Parameters: none. Block geometry comes from the shared package.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- icache_miss  in  1  level; I-cache miss pending
- icache_miss_addr  in  16  I-cache miss address
- dcache_miss  in  1  level; D-cache miss pending
- dcache_miss_addr  in  16  D-cache miss address
- mem_en  out  1  memory read request this cycle
- mem_addr  out  16  read address (word aligned)
- mem_data_valid  in  1  read data returning this cycle
- mem_data_in  in  16  read data
- mem_busy  out  1  controller not IDLE; store traffic must hold off
- fill_target  out  1  0 = I-cache, 1 = D-cache
- fill_word_wr  out  1  write fill_data_out into the target data array
- fill_word_addr  out  16  address of the word being written
- fill_data_out  out  16  word to write (= mem_data_in)
- tag_wr  out  1  write tag/valid for fill_word_addr's set in the target
- icache_fill_done  out  1  one-cycle completion pulse
- dcache_fill_done  out  1  one-cycle completion pulse
- icache_stall  out  1  I-side pipeline stall
- dcache_stall  out  1  D-side pipeline stall

## Operation
- States: IDLE, ISSUE, DRAIN.
- **IDLE**
  - If dcache_miss: latch base = dcache_miss_addr & 16'hFFF0 and target = 1, then go to ISSUE.
  - Else if icache_miss: latch base = icache_miss_addr & 16'hFFF0 and target = 0, then go to ISSUE.
  - The D-cache wins simultaneous misses. Grants are non-preemptive.
- **ISSUE**
  - mem_en = 1 and mem_addr = base | (issue_cnt << 1).
  - issue_cnt runs 0..7. After the cycle with issue_cnt = 7, go to DRAIN.
- **Receive path** (ISSUE and DRAIN)
  - Each mem_data_valid cycle: fill_word_wr = 1, fill_word_addr = base | (recv_cnt << 1), fill_data_out = mem_data_in, and recv_cnt increments.
  - On the valid with recv_cnt = 7: tag_wr = 1 and the target's fill_done = 1 (same cycle as the last word write), then go to IDLE.
- Words arrive in issue order. The memory accepts one request per cycle.
- mem_data_valid in IDLE is ignored: no writes, no counter change.
- Stall outputs (combinational):
  - icache_stall = icache_miss | (busy & target == 0)
  - dcache_stall = dcache_miss | (busy & target == 1)
- Requesters must drop their miss the cycle after fill_done, since the tag is written at that edge. No re-grant occurs from a stale miss.
- Counters are 3-bit and wrap 7 -> 0. Offset bits [3:1] come only from the counters; base[3:0] is always 0.
- Reset in any state forces IDLE and clears both counters and the latched base/target. Memory returns still in flight after reset are discarded.

## Timing
- Reset values: all outputs 0.
- With the miss visible in cycle T:
  - mem_en is high in T+1..T+8.
  - With a memory latency of L cycles, words are written in T+1+L..T+8+L.
  - tag_wr and fill_done fire in T+8+L.
  - IDLE is re-entered in T+9+L.
- For L = 4: done at T+12, and a new grant is possible at T+13.
- Minimum occupancy is 9 cycles (ISSUE 8 cycles plus at least one DRAIN or final cycle).
- Gaps in mem_data_valid extend DRAIN without limit. No timeout.

## Structure
- Shared package cache_pkg:
  - BLOCK_WORDS = 8
  - OFFSET_BITS = 4
  - SET_BITS = 6
  - TARGET_I / TARGET_D
  - enum fill_state_t {IDLE, ISSUE, DRAIN}
- One sub-module, cache_fill_counter: 3-bit counter with synchronous clear and enable, instanced for issue_cnt and recv_cnt.

## Test plan
- **I-miss only:** icache_miss = 1, addr 16'h1234, L = 4. Expect mem_addr 16'h1230..16'h123E over T+1..T+8, eight fill_word_wr in T+5..T+12, and tag_wr plus icache_fill_done at T+12 with fill_target = 0.
- **Simultaneous misses:** I addr 16'h0040, D addr 16'h0380.
  - The D fill (base 16'h0380) completes first, while icache_stall stays high.
  - The I fill starts in the cycle after D returns to IDLE.
- **Late miss during busy:** icache_miss arrives mid D-fill. Expect no preemption: the D words all carry fill_target = 1 and the I grant follows D done.
- **Irregular returns:** memory with a 2-cycle bubble after word 3. Expect the DRAIN extension, correct word addresses (offsets 0x0..0xE in order), and done only on the 8th valid.
- **Reset mid-fill:** rst asserted after word 4 is written. Next cycle expect every output 0 and state IDLE; following stray mem_data_valid pulses produce no fill_word_wr or tag_wr.
- **Set-boundary address:** miss addr 16'hFFFF. Expect base 16'hFFF0 (set 63), last word 16'hFFFE, and no carry out of the offset bits.
